// File: rtl/cnn_chan_reduce.sv
// cnn_chan_reduce: sums CH signed channels per beat over NACC beats, shifts,
// narrows to OUT_W bits and hands the result to a transmitter.
// Optional macro CNN_RED_SAT_EN: saturate on narrowing and flag clipping on ovf;
// when undefined the result wraps and ovf stays 0.
module cnn_chan_reduce #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DW    = 18,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned NACC  = 1,
  parameter int unsigned SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    strt,
  input  logic                    vld,
  input  logic [CH*DW-1:0]        din,
  input  logic                    tx_done,
  output logic                    bsy,
  output logic                    trmt,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam int unsigned AW = DW + $clog2(CH) + $clog2(NACC) + 1;
  localparam int unsigned CW = (NACC > 1) ? $clog2(NACC) : 1;
  localparam int unsigned EW = ((AW > OUT_W) ? AW : OUT_W) + 1;

  typedef enum logic [1:0] {IDLE, ACC, OUT, WAIT} state_t;

  state_t                  state;
  logic signed [AW-1:0]    acc;
  logic [CW-1:0]           cnt;
  logic signed [AW-1:0]    beat_sum;
  logic signed [AW-1:0]    total;
  logic signed [AW-1:0]    shifted;
  logic signed [EW-1:0]    ext;
  logic signed [OUT_W-1:0] res;
  logic                    clip;

  // Signed sum of all channels of the current beat
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < CH; k++) begin
      beat_sum = beat_sum + AW'($signed(din[k*DW +: DW]));
    end
  end

  // Running total including the current beat, scaled and sign-extended
  always_comb begin
    total   = acc + beat_sum;
    shifted = total >>> SHIFT;
    ext     = EW'(shifted);
  end

`ifdef CNN_RED_SAT_EN
  localparam logic signed [EW-1:0] SAT_MAX = EW'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp the scaled total into the signed output range
  always_comb begin
    res  = ext[OUT_W-1:0];
    clip = 1'b0;
    if (ext > SAT_MAX) begin
      res  = OUT_W'(SAT_MAX);
      clip = 1'b1;
    end else if (ext < SAT_MIN) begin
      res  = OUT_W'(SAT_MIN);
      clip = 1'b1;
    end
  end
`else
  logic unused_hi;

  // Keep only the low output bits; clipping is never reported
  always_comb begin
    res       = ext[OUT_W-1:0];
    clip      = 1'b0;
    unused_hi = ^ext[EW-1:OUT_W];
  end
`endif

  // Control FSM with accumulator, beat counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      bsy   <= 1'b0;
      trmt  <= 1'b0;
      dout  <= '0;
      ovf   <= 1'b0;
    end else begin
      trmt <= 1'b0;
      case (state)
        IDLE: begin
          if (strt) begin
            acc   <= '0;
            cnt   <= '0;
            bsy   <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          if (vld) begin
            if (cnt == CW'(NACC - 1)) begin
              dout  <= res;
              ovf   <= clip;
              trmt  <= 1'b1;
              state <= OUT;
            end else begin
              acc <= total;
              cnt <= cnt + CW'(1);
            end
          end
        end
        OUT: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            bsy   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cnn_chan_reduce.md
CNN_CHAN_REDUCE -- requirements
Module: cnn_chan_reduce

Interface
REQ-001 SHALL have parameter CH, default 4: number of input channels summed per beat.
REQ-002 SHALL have parameter DW, default 18: signed two's-complement width of each channel value.
REQ-003 SHALL have parameter OUT_W, default 8: signed result width.
REQ-004 SHALL have parameter NACC, default 1: beats accumulated per result (range 1..256).
REQ-005 SHALL have parameter SHIFT, default 0: arithmetic right shift applied before output narrowing.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port strt  input  1  starts one reduction when idle.
REQ-009 SHALL have port vld  input  1  din beat valid.
REQ-010 SHALL have port din  input  CH*DW  channel values, channel k at bits [k*DW +: DW].
REQ-011 SHALL have port tx_done  input  1  downstream transmitter finished consuming dout.
REQ-012 SHALL have port bsy  output  1  reduction or transmit in progress.
REQ-013 SHALL have port trmt  output  1  one-cycle pulse: dout valid, start transmit.
REQ-014 SHALL have port dout  output  OUT_W  signed result, held until the next result.
REQ-015 SHALL have port ovf  output  1  result was clipped; valid with dout.

Function
REQ-016 SHALL implement states IDLE, ACC, OUT, WAIT; all outputs registered.
REQ-017 IDLE: bsy=0; strt=1 -> clear accumulator and beat counter, enter ACC, bsy=1 from next cycle.
REQ-018 ACC: each cycle with vld=1 SHALL add the signed sum of all CH channels to the accumulator and increment the beat counter; vld=0 stalls with no state change.
REQ-019 Accumulator width SHALL be DW+clog2(CH)+clog2(NACC)+1 bits; no internal overflow is possible.
REQ-020 The beat accepted with counter = NACC-1 SHALL transition to OUT; dout and ovf SHALL load at that same edge from (accumulator + current beat) >>> SHIFT.
REQ-021 OUT: trmt=1 for exactly this one cycle, then unconditional transition to WAIT.
REQ-022 WAIT: hold dout and ovf; tx_done=1 -> IDLE with bsy=0 at the next edge.
REQ-023 Latency: trmt SHALL be high in the cycle immediately after the last accepted beat.
REQ-024 strt SHALL be ignored outside IDLE; vld SHALL be ignored outside ACC; tx_done SHALL be ignored outside WAIT, including in the OUT cycle.
REQ-025 strt and vld high together in IDLE SHALL start the reduction but not accept that beat.
REQ-026 dout and ovf SHALL keep their last values through IDLE and ACC until the next OUT load.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, and set bsy=0, trmt=0, dout=0, ovf=0, accumulator=0 and beat counter=0, regardless of clk.
REQ-028 Reset asserted mid-ACC or mid-WAIT SHALL discard the partial result; the first strt after release SHALL begin a fresh reduction.

Configuration
REQ-029 Macro CNN_RED_SAT_EN defined: the shifted value SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and ovf=1 whenever clipping occurs.
REQ-030 Macro CNN_RED_SAT_EN undefined: dout SHALL be the low OUT_W bits of the shifted value (wrap), and ovf SHALL be constant 0.

Verification (CH=4, DW=18, OUT_W=8 unless stated)
REQ-031 NACC=1, SHIFT=0; strt, then vld with din={1,2,3,4} -> next cycle trmt=1 with dout=10 and ovf=0; bsy stays 1 until the edge after tx_done.
REQ-032 din={100,100,100,100} -> with macro: dout=127, ovf=1; without macro: dout=0x90 (-112), ovf=0.
REQ-033 din={-100,-100,-100,-100} with macro -> dout=-128, ovf=1.
REQ-034 NACC=3, SHIFT=2; beats summing 4, 8 and 12, with two vld=0 gap cycles -> single trmt with dout=6, one cycle after the third beat.
REQ-035 strt pulsed during ACC and WAIT, and tx_done pulsed during ACC and OUT -> no effect; only one trmt is produced, and the block exits WAIT only on a tx_done in WAIT.
REQ-036 rst pulsed mid-ACC after 1 of 3 beats -> all outputs 0 asynchronously; a new strt plus 3 beats of sum 4 each yields dout=3 (12>>>2).
